// File: rtl/lane_quad_sequencer.sv
// rtl/lane_quad_sequencer.sv - presents a 64-lane exec mask as 16-lane quad beats.
// Optional quad skipping of all-zero slices is compiled in with QUAD_SKIP_EN.
module lane_quad_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] exec_mask,
  input  logic [5:0]  wfid,
  input  logic        stall,
  output logic        busy,
  output logic        lane_valid,
  output logic [15:0] lane_en,
  output logic [1:0]  quad_idx,
  output logic [5:0]  wfid_out,
  output logic        last,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [63:0] mask_q, mask_d;
  logic [5:0]  wfid_q, wfid_d;
  logic [1:0]  quad_q, quad_d;
  logic        valid_q, valid_d;
  logic [15:0] en_q, en_d;
  logic        last_q, last_d;
  logic        done_q, done_d;

  logic [63:0] src_mask;
  logic [2:0]  lo;
  logic [2:0]  nxt;
  logic        nxt_last;

`ifdef QUAD_SKIP_EN
  logic [3:0]  nz;
  logic [2:0]  after;

  function automatic logic [3:0] nz_flags(input logic [63:0] m);
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = |m[16*i +: 16];
    return f;
  endfunction

  // Returns {found, index} of the lowest nonzero quad at or above lo_q.
  function automatic logic [2:0] first_at_or_above(input logic [3:0] f, input logic [2:0] lo_q);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (f[i] && (3'(i) >= lo_q)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction
`endif

  // Candidate quad to present next: from the live inputs when accepting, from the capture otherwise.
  always_comb begin
    src_mask = (state_q == IDLE) ? exec_mask : mask_q;
    lo       = (state_q == IDLE) ? 3'd0 : ({1'b0, quad_q} + 3'd1);
`ifdef QUAD_SKIP_EN
    nz       = nz_flags(src_mask);
    nxt      = first_at_or_above(nz, lo);
    after    = first_at_or_above(nz, {1'b0, nxt[1:0]} + 3'd1);
    nxt_last = ~after[2];
`else
    nxt      = {1'b1, lo[1:0]};
    nxt_last = (lo[1:0] == 2'd3);
`endif
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    wfid_d  = wfid_q;
    quad_d  = quad_q;
    valid_d = valid_q;
    en_d    = en_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        en_d    = 16'h0000;
        last_d  = 1'b0;
        quad_d  = 2'd0;
        if (start) begin
          mask_d = exec_mask;
          wfid_d = wfid;
          if (nxt[2]) begin
            state_d = RUN;
            valid_d = 1'b1;
            quad_d  = nxt[1:0];
            en_d    = 16'(src_mask >> {nxt[1:0], 4'd0});
            last_d  = nxt_last;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            en_d    = 16'h0000;
            last_d  = 1'b0;
            quad_d  = 2'd0;
            done_d  = 1'b1;
          end else begin
            quad_d  = nxt[1:0];
            en_d    = 16'(src_mask >> {nxt[1:0], 4'd0});
            last_d  = nxt_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= 64'd0;
      wfid_q  <= 6'd0;
      quad_q  <= 2'd0;
      valid_q <= 1'b0;
      en_q    <= 16'h0000;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      wfid_q  <= wfid_d;
      quad_q  <= quad_d;
      valid_q <= valid_d;
      en_q    <= en_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign lane_valid = valid_q;
  assign lane_en    = en_q;
  assign quad_idx   = quad_q;
  assign wfid_out   = wfid_q;
  assign last       = last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lane_quad_sequencer.sv
// tb/tb_lane_quad_sequencer.sv - randomized self-checking bench for lane_quad_sequencer.
// Reference model keeps the list of quads still to be presented as a queue.
module tb_lane_quad_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] exec_mask;
  logic [5:0]  wfid;
  logic        stall;
  logic        busy;
  logic        lane_valid;
  logic [15:0] lane_en;
  logic [1:0]  quad_idx;
  logic [5:0]  wfid_out;
  logic        last;
  logic        done;

  lane_quad_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .exec_mask  (exec_mask),
    .wfid       (wfid),
    .stall      (stall),
    .busy       (busy),
    .lane_valid (lane_valid),
    .lane_en    (lane_en),
    .quad_idx   (quad_idx),
    .wfid_out   (wfid_out),
    .last       (last),
    .done       (done)
  );

  always #5 clk = ~clk;

  int          m_q[$];
  logic [63:0] m_mask;
  logic [5:0]  m_wfid;
  logic        m_done;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mask = 64'd0;
    m_wfid = 6'd0;
    m_done = 1'b0;
  endtask

  // Expected effect of one clock edge given the inputs applied before it.
  task automatic model_step(input logic st, input logic [63:0] m, input logic [5:0] w, input logic sl);
    m_done = 1'b0;
    if (m_q.size() > 0) begin
      if (!sl) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1'b1;
      end
    end else if (st) begin
      m_mask = m;
      m_wfid = w;
      for (int qd = 0; qd < 4; qd++) begin
`ifdef QUAD_SKIP_EN
        if (m[16*qd +: 16] != 16'h0000) m_q.push_back(qd);
`else
        m_q.push_back(qd);
`endif
      end
      if (m_q.size() == 0) m_done = 1'b1;
    end
  endtask

  task automatic check_outputs();
    logic v;
    v = (m_q.size() > 0);
    check("busy", busy, v);
    check("lane_valid", lane_valid, v);
    check("lane_en", lane_en, v ? m_mask[16*m_q[0] +: 16] : 16'h0000);
    if (v) check("quad_idx", quad_idx, m_q[0]);
    check("last", last, v && (m_q.size() == 1));
    check("done", done, m_done);
    check("wfid_out", wfid_out, m_wfid);
  endtask

  task automatic check_reset_state();
    check("rst_busy", busy, 0);
    check("rst_valid", lane_valid, 0);
    check("rst_lane_en", lane_en, 0);
    check("rst_quad", quad_idx, 0);
    check("rst_wfid", wfid_out, 0);
    check("rst_last", last, 0);
    check("rst_done", done, 0);
  endtask

  task automatic cycle(input logic st, input logic [63:0] m, input logic [5:0] w, input logic sl);
    @(negedge clk);
    check_outputs();
    start     = st;
    exec_mask = m;
    wfid      = w;
    stall     = sl;
    model_step(st, m, w, sl);
  endtask

  function automatic logic [63:0] rand_mask();
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 3))
        0:       r[16*i +: 16] = 16'h0000;
        1:       r[16*i +: 16] = 16'hFFFF;
        default: r[16*i +: 16] = 16'($urandom);
      endcase
    end
    return r;
  endfunction

  initial begin
    rst = 1'b0; start = 1'b0; exec_mask = 64'd0; wfid = 6'd0; stall = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_state();
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Single-quad mask, then idle until done has passed.
    cycle(1'b1, 64'h0000_0000_0000_FFFF, 6'd3, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 64'd0, 6'd0, 1'b0);

    // First and last quad only.
    cycle(1'b1, 64'hFFFF_0000_0000_0001, 6'd9, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 64'd0, 6'd0, 1'b0);

    // All-zero mask.
    cycle(1'b1, 64'd0, 6'd12, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 6'd0, 1'b0);

    // Full mask, stall held on quad 1, stray start while busy.
    cycle(1'b1, {4{16'hFFFF}}, 6'd7, 1'b0);
    cycle(1'b1, 64'h1234_5678_9ABC_DEF0, 6'd33, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 6'd0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 64'd0, 6'd0, 1'b0);

    // Continuous start: a new request is taken in each done cycle.
    for (int i = 0; i < 14; i++) cycle(1'b1, rand_mask(), 6'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 64'd0, 6'd0, 1'b0);

    // Reset in the middle of a full-mask request.
    cycle(1'b1, {4{16'hA5A5}}, 6'd21, 1'b0);
    cycle(1'b0, 64'd0, 6'd0, 1'b0);
    cycle(1'b0, 64'd0, 6'd0, 1'b0);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 64'd0, 6'd0, 1'b0);
    cycle(1'b1, {4{16'hFFFF}}, 6'd5, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 64'd0, 6'd0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 1) == 1), rand_mask(), 6'($urandom), ($urandom_range(0, 9) < 3));
    end
    @(negedge clk);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
